// File: rtl/serial_ripple_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, BITS_PER_CYCLE bits per clock, LSB chunk first.
// Optional SUB_OVERFLOW_FLAG_EN adds a registered signed-overflow output ovf.
module serial_ripple_subtractor #(
    parameter int WIDTH          = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("serial_ripple_subtractor: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state;
    logic [WIDTH-1:0]          a_p0;
    logic [WIDTH-1:0]          b_p0;
    logic [CW-1:0]             cnt;
    logic                      borrow;
    logic [31:0]               base;
    logic [BITS_PER_CYCLE-1:0] chunk_d;
    logic                      chunk_br;

    // Bit-serial full-subtractor chain across one chunk; returns {borrow_out, difference}.
    function automatic logic [BITS_PER_CYCLE:0] sub_chunk(
        input logic [BITS_PER_CYCLE-1:0] x,
        input logic [BITS_PER_CYCLE-1:0] y,
        input logic                      br_in
    );
        logic [BITS_PER_CYCLE:0] r;
        logic                    br;
        r  = '0;
        br = br_in;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            r[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        r[BITS_PER_CYCLE] = br;
        return r;
    endfunction

    assign base = 32'(cnt) * BITS_PER_CYCLE;
    assign {chunk_br, chunk_d} = sub_chunk(a_p0[base +: BITS_PER_CYCLE],
                                           b_p0[base +: BITS_PER_CYCLE], borrow);

    assign in_ready = (state == IDLE) && rst_n;

    // Operand registers carry no reset; everything visible to the consumer does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            borrow    <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_p0   <= a;
                        b_p0   <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    diff[base +: BITS_PER_CYCLE] <= chunk_d;
                    borrow <= chunk_br;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        bout      <= chunk_br;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef SUB_OVERFLOW_FLAG_EN
                        // The top chunk's MSB is the final diff MSB.
                        ovf <= (a_p0[WIDTH-1] != b_p0[WIDTH-1]) &&
                               (chunk_d[BITS_PER_CYCLE-1] != a_p0[WIDTH-1]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
